// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, the state word type and the
// FSM encoding used by the sequential InvSubBytes engine.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } isb_state_e;

    // Bit position of the least significant bit of byte byte_idx in a state word.
    function automatic logic [6:0] byte_lsb(input logic [3:0] byte_idx);
        return {byte_idx, 3'b000};
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
// The table is stored with entry 0x00 in the most significant byte.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] sbox_in,
    output logic [AES_BYTE_W-1:0] sbox_out
);

    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Table lookup: entry n sits at bits [2047-8n -: 8], i.e. {~n, 3'b111}.
    always_comb begin
        sbox_out = INV_TABLE[{~sbox_in, 3'b111} -: AES_BYTE_W];
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine. Captures a 128-bit state on a
// valid/ready handshake, substitutes LANES bytes per clock (lowest bytes
// first) through shared inverse S-boxes and presents the result until the
// downstream accepts it. The DONE cycle can overlap the next capture.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int NBEAT = AES_NBYTES / LANES;
    localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEAT - 1);

    isb_state_e             state_r;
    isb_state_e             state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_s;
    logic [AES_STATE_W-1:0] buf_r;
    logic [AES_STATE_W-1:0] buf_s;
    logic [AES_STATE_W-1:0] out_state_r;
    logic [AES_STATE_W-1:0] out_state_s;
    logic [3:0]             lane_idx_s [LANES];
    logic [AES_BYTE_W-1:0]  sb_in_s    [LANES];
    logic [AES_BYTE_W-1:0]  sb_out_s   [LANES];
    logic                   last_beat_s;

    // Lane mux: select the LANES bytes handled in the current beat.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx_s[k] = 4'(int'(cnt_r) * LANES + k);
            sb_in_s[k]    = buf_r[byte_lsb(lane_idx_s[k]) +: AES_BYTE_W];
        end
        last_beat_s = (cnt_r == CNT_LAST);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .sbox_in  (sb_in_s[g]),
            .sbox_out (sb_out_s[g])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_beat_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready && in_valid) begin
                    state_s = ST_BUSY;
                end else if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode; in_ready follows out_ready only while a result is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_BUSY: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath next values: capture, per-beat lane demux, result latch.
    always_comb begin
        buf_s       = buf_r;
        cnt_s       = cnt_r;
        out_state_s = out_state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_s = in_state;
                    cnt_s = CNT_ZERO;
                end else begin
                    buf_s = buf_r;
                    cnt_s = cnt_r;
                end
            end
            ST_BUSY: begin
                for (int k = 0; k < LANES; k++) begin
                    buf_s[byte_lsb(lane_idx_s[k]) +: AES_BYTE_W] = sb_out_s[k];
                end
                if (last_beat_s) begin
                    cnt_s       = CNT_ZERO;
                    out_state_s = buf_s;
                end else begin
                    cnt_s       = cnt_r + CNT_ONE;
                    out_state_s = out_state_r;
                end
            end
            ST_DONE: begin
                if (out_ready && in_valid) begin
                    buf_s = in_state;
                    cnt_s = CNT_ZERO;
                end else begin
                    buf_s = buf_r;
                    cnt_s = cnt_r;
                end
            end
            default: begin
                buf_s       = buf_r;
                cnt_s       = CNT_ZERO;
                out_state_s = out_state_r;
            end
        endcase
    end

    // Datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r       <= {AES_STATE_W{1'b0}};
            cnt_r       <= CNT_ZERO;
            out_state_r <= {AES_STATE_W{1'b0}};
        end else begin
            buf_r       <= buf_s;
            cnt_r       <= cnt_s;
            out_state_r <= out_state_s;
        end
    end

    assign out_state = out_state_r;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench: five engines (LANES 1,2,4,8,16) share clock and reset.
// Expected results come from an inverse table built from GF(2^8) arithmetic
// and are queued at accept time, then popped when a result is handed off.
module tb_inv_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic         in_valid  [5];
    logic         in_ready  [5];
    logic [127:0] in_state  [5];
    logic         out_valid [5];
    logic         out_ready [5];
    logic [127:0] out_state [5];
    logic         busy      [5];

    logic [7:0]   inv_tab [256];
    logic [127:0] exp_q [$];
    int           n_checks;
    int           n_fail;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward S-box from inverse + affine transform, then invert it.
    task automatic build_model();
        logic [7:0] xv;
        logic [7:0] iv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            xv = 8'(x);
            iv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xv, 8'(y)) == 8'h01) iv = 8'(y);
            end
            s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                   ^ {iv[3:0], iv[7:4]} ^ 8'h63;
            inv_tab[s] = xv;
        end
    endtask

    function automatic logic [127:0] ref_inv(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[v[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [127:0] obs);
        chk({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) chk(tag, obs, exp_q.pop_front());
    endtask

    // One full transaction on engine idx with out_ready held high.
    task automatic txn(input int idx, input logic [127:0] v, input logic [127:0] exp,
                       input int nbeat, input string tag);
        int t;
        int lat;
        @(negedge clk);
        in_state[idx] = v; in_valid[idx] = 1'b1; out_ready[idx] = 1'b1;
        #1;
        t = 0;
        while (in_ready[idx] !== 1'b1 && t < 50) begin @(negedge clk); #1; t++; end
        chk({tag, "_accept"}, 128'(in_ready[idx]), 128'd1);
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid[idx] = 1'b0; in_state[idx] = ~v;
        #1;
        lat = 0;
        while (out_valid[idx] !== 1'b1 && lat < 100) begin @(negedge clk); #1; lat++; end
        chk({tag, "_latency"}, 128'(lat), 128'(nbeat));
        pop_chk({tag, "_data"}, out_state[idx]);
        @(negedge clk);
        #1;
        chk({tag, "_released"}, 128'(out_valid[idx]), 128'd0);
        chk({tag, "_hold"}, out_state[idx], exp);
    endtask

    initial begin
        logic [127:0] bvec [3];
        logic [127:0] v;
        int sent; int got; int last; int cyc; int ov_seen; bit adv;
        n_checks = 0;
        n_fail   = 0;
        build_model();
        for (int i = 0; i < 5; i++) begin
            in_valid[i] = 1'b0; in_state[i] = 128'd0; out_ready[i] = 1'b0;
        end

        // Reset state of every engine.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_in_ready", 128'(in_ready[i]), 128'd1);
            chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
            chk("rst_busy", 128'(busy[i]), 128'd0);
            chk("rst_out_state", out_state[i], 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors on the LANES=4 engine.
        txn(2, 128'h637c777bf26b6fc53001672bfed7ab76,
            128'h000102030405060708090a0b0c0d0e0f, 4, "vec_fips");
        txn(2, 128'd0, {16{8'h52}}, 4, "vec_zero");
        txn(2, {16{8'h16}}, {16{8'hff}}, 4, "vec_16");

        // Backpressure: result held for 10 cycles, pending input not taken.
        @(negedge clk);
        v = 128'h0123456789abcdeffedcba9876543210;
        in_state[2] = v; in_valid[2] = 1'b1; out_ready[2] = 1'b0;
        #1;
        chk("bp_accept", 128'(in_ready[2]), 128'd1);
        exp_q.push_back(ref_inv(v));
        @(negedge clk);
        in_state[2] = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        #1;
        cyc = 0;
        while (out_valid[2] !== 1'b1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid[2]), 128'd1);
            chk("bp_out_state", out_state[2], ref_inv(v));
            chk("bp_in_ready", 128'(in_ready[2]), 128'd0);
            chk("bp_busy", 128'(busy[2]), 128'd0);
            @(negedge clk);
            #1;
        end
        pop_chk("bp_data", out_state[2]);
        in_valid[2] = 1'b0; out_ready[2] = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_rel_out_valid", 128'(out_valid[2]), 128'd0);
        chk("bp_rel_in_ready", 128'(in_ready[2]), 128'd1);
        chk("bp_rel_busy", 128'(busy[2]), 128'd0);

        // Back-to-back stream of three vectors.
        for (int i = 0; i < 3; i++) bvec[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0; got = 0; last = -1; cyc = 0; adv = 1'b0;
        @(negedge clk);
        in_state[2] = bvec[0]; in_valid[2] = 1'b1; out_ready[2] = 1'b1;
        while (got < 3 && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                sent++;
                if (sent < 3) in_state[2] = bvec[sent];
                else in_valid[2] = 1'b0;
            end
            #1;
            if (out_valid[2] && out_ready[2]) begin
                pop_chk("b2b_data", out_state[2]);
                if (last >= 0) chk("b2b_period", 128'(cyc - last), 128'd5);
                last = cyc;
                got++;
            end
            if (in_valid[2] && in_ready[2]) begin
                exp_q.push_back(ref_inv(in_state[2]));
                adv = 1'b1;
            end
            cyc++;
        end
        chk("b2b_count", 128'(got), 128'd3);
        @(negedge clk);
        in_valid[2] = 1'b0;

        // Reset while BUSY with cnt=2.
        @(negedge clk);
        in_state[2] = 128'h00112233445566778899aabbccddeeff; in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_busy", 128'(busy[2]), 128'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready[2]), 128'd1);
        chk("mid_rst_out_valid", 128'(out_valid[2]), 128'd0);
        chk("mid_rst_busy", 128'(busy[2]), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (out_valid[2] !== 1'b0) ov_seen++;
        end
        chk("mid_rst_no_output", 128'(ov_seen), 128'd0);
        v = 128'h8e2b7ad5c3019f4466d07ab2e1c95f38;
        txn(2, v, ref_inv(v), 4, "post_rst");

        // Exhaustive byte coverage on every LANES setting.
        for (int idx = 0; idx < 5; idx++) begin
            for (int n = 0; n < 16; n++) begin
                for (int b = 0; b < 16; b++) v[8*b +: 8] = 8'(n * 16 + b);
                txn(idx, v, ref_inv(v), 16 >> idx, $sformatf("sweep_l%0d_v%0d", 1 << idx, n));
            end
        end

        chk("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
